idct_tpose_ctrl: RTL and testbench

Ping-pong transpose buffer controller for the IDCT pipeline, placed between the row 1-D IDCT and the column 1-D IDCT. It accepts 8x8 blocks of coefficients in row-major order on a valid/ready stream and writes them into one of two 64-entry banks. It streams each completed block out in column-major order from that bank while the other bank fills. The result is sustained throughput of one sample per clock.

---
 rtl/idct_tpose_ctrl_pkg.sv | 17 +
 rtl/idct_tpose_ctrl_bank.sv | 38 +++
 rtl/idct_tpose_ctrl.sv | 144 ++++++++++++++
 tb/tb_idct_tpose_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_tpose_ctrl_pkg.sv
// Shared definitions for the IDCT ping-pong transpose buffer: block size,
// bank occupancy encoding and the row-major to column-major address swap.
package idct_tpose_ctrl_pkg;

    localparam int unsigned BLK_N = 64;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    // Output sample k reads input element (k%8)*8 + k/8.
    function automatic logic [5:0] tpose_addr(input logic [5:0] k);
        return {k[2:0], k[5:3]};
    endfunction

endpackage

// File: rtl/idct_tpose_ctrl_bank.sv
// One 64-entry transpose bank: synchronous write port and a registered read
// port whose output clears on reset/flush and holds while r_en is low.
module idct_tpose_bank
    import idct_tpose_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH_X = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               w_en,
    input  logic [5:0]         w_addr,
    input  logic [WIDTH_X-1:0] d_in,
    input  logic               r_en,
    input  logic [5:0]         r_addr,
    output logic [WIDTH_X-1:0] d_out
);

    logic [WIDTH_X-1:0] mem [BLK_N];

    // Storage has no reset so a flush leaves contents untouched.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= d_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out <= '0;
        end else if (clr) begin
            d_out <= '0;
        end else if (r_en) begin
            d_out <= mem[r_addr];
        end
    end

endmodule

// File: rtl/idct_tpose_ctrl.sv
// Ping-pong transpose controller: fills one bank row-major from the row IDCT
// while draining the other column-major to the column IDCT.
module idct_tpose_ctrl
    import idct_tpose_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH_X = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_X-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_X-1:0] out_data,
    output logic               out_last
);

    bank_state_e        bstate     [2];
    bank_state_e        bstate_nxt [2];

    logic               wbank;
    logic               rbank;
    logic               rd_sel;
    logic [5:0]         wcnt;
    logic [5:0]         rcnt;

    logic               wr_fire;
    logic               issue;
    logic               w_en0;
    logic               w_en1;
    logic               r_en0;
    logic               r_en1;
    logic [WIDTH_X-1:0] d_out0;
    logic [WIDTH_X-1:0] d_out1;

    // Bank occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate[0] <= BANK_EMPTY;
            bstate[1] <= BANK_EMPTY;
        end else if (clr) begin
            bstate[0] <= BANK_EMPTY;
            bstate[1] <= BANK_EMPTY;
        end else begin
            bstate[0] <= bstate_nxt[0];
            bstate[1] <= bstate_nxt[1];
        end
    end

    // Write completion and read completion always target different banks,
    // so both updates can apply in the same cycle.
    always_comb begin
        bstate_nxt[0] = bstate[0];
        bstate_nxt[1] = bstate[1];
        if (wr_fire && (wcnt == '1)) begin
            bstate_nxt[wbank] = BANK_FULL;
        end
        if (issue && (rcnt == '1)) begin
            bstate_nxt[rbank] = BANK_EMPTY;
        end
    end

    always_comb begin
        in_ready = (bstate[wbank] == BANK_EMPTY);
        wr_fire  = in_valid && in_ready && !clr;
        issue    = (bstate[rbank] == BANK_FULL) && (!out_valid || out_ready) && !clr;
        w_en0    = wr_fire && !wbank;
        w_en1    = wr_fire &&  wbank;
        r_en0    = issue && !rbank;
        r_en1    = issue &&  rbank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank <= 1'b0;
            wcnt  <= '0;
        end else if (clr) begin
            wbank <= 1'b0;
            wcnt  <= '0;
        end else if (wr_fire) begin
            wcnt <= wcnt + 6'd1;
            if (wcnt == '1) begin
                wbank <= ~wbank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank     <= 1'b0;
            rcnt      <= '0;
            rd_sel    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (clr) begin
            rbank     <= 1'b0;
            rcnt      <= '0;
            rd_sel    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (issue) begin
            rcnt      <= rcnt + 6'd1;
            rd_sel    <= rbank;
            out_valid <= 1'b1;
            out_last  <= (rcnt == '1);
            if (rcnt == '1) begin
                rbank <= ~rbank;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // rd_sel only moves on issue, so out_data holds with the bank outputs.
    assign out_data = rd_sel ? d_out1 : d_out0;

    idct_tpose_bank #(.WIDTH_X(WIDTH_X)) u_bank0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .w_en   (w_en0),
        .w_addr (wcnt),
        .d_in   (in_data),
        .r_en   (r_en0),
        .r_addr (tpose_addr(rcnt)),
        .d_out  (d_out0)
    );

    idct_tpose_bank #(.WIDTH_X(WIDTH_X)) u_bank1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .w_en   (w_en1),
        .w_addr (wcnt),
        .d_in   (in_data),
        .r_en   (r_en1),
        .r_addr (tpose_addr(rcnt)),
        .d_out  (d_out1)
    );

endmodule

// File: tb/tb_idct_tpose_ctrl.sv
// Bench for idct_tpose_ctrl: directed and random traffic checked against a
// block-level transpose model built from queues.
module tb_idct_tpose_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    logic [15:0] in_buf[$];
    logic [15:0] exp_q[$];
    int unsigned out_cnt = 0;
    int unsigned acc_cnt = 0;
    logic        hold_pend = 1'b0;
    logic [15:0] hold_data = '0;
    logic        hold_last = 1'b0;

    idct_tpose_ctrl #(.WIDTH_X(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_buf.delete();
        exp_q.delete();
        out_cnt   = 0;
        acc_cnt   = 0;
        hold_pend = 1'b0;
    endtask

    // Handshakes seen here complete at the following rising edge.
    task automatic observe();
        if (!rst_n) return;
        if (clr) begin
            model_reset();
            return;
        end
        if (hold_pend) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hold_data);
            check("hold_last", out_last, hold_last);
        end
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
        hold_last = out_last;
        if (in_valid && in_ready) begin
            in_buf.push_back(in_data);
            acc_cnt++;
            if (in_buf.size() == 64) begin
                for (int k = 0; k < 64; k++) exp_q.push_back(in_buf[(k % 8) * 8 + k / 8]);
                in_buf.delete();
            end
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
                check("out_last", out_last, (out_cnt % 64) == 63);
                out_cnt++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        clr      = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drain(input string tag, input int unsigned bound);
        int unsigned n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < bound) begin
            cycle();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic send_block(input logic rnd);
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = rnd ? 16'($urandom) : 16'(i);
            cycle();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int unsigned base;
        int unsigned n;
        logic        started;

        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_ready", in_ready, 1);

        // Single block with first-valid latency
        out_ready = 1'b1;
        send_block(1'b0);
        check("lat_e", out_valid, 0);
        cycle();
        check("lat_e1_valid", out_valid, 1);
        check("lat_e1_data", out_data, 0);
        drain("single_drain", 200);

        // Back-to-back, four blocks
        do_reset();
        out_ready = 1'b1;
        base      = out_cnt;
        started   = 1'b0;
        n         = 0;
        while ((out_cnt - base < 256) && n < 600) begin
            if (out_valid) started = 1'b1;
            if (started) check("no_gap", out_valid, 1);
            if (acc_cnt < 256) begin
                check("b2b_ready", in_ready, 1);
                in_valid = 1'b1;
                in_data  = 16'(acc_cnt);
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            n++;
        end
        check("b2b_count", out_cnt - base, 256);

        // Back-pressure over three blocks
        do_reset();
        out_ready = 1'b0;
        for (int t = 0; t < 150; t++) begin
            in_valid = 1'b1;
            in_data  = 16'(acc_cnt);
            cycle();
        end
        check("bp_accepts", acc_cnt, 128);
        check("bp_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 0);
        out_ready = 1'b1;
        n = 0;
        while ((acc_cnt < 192 || exp_q.size() > 0) && n < 600) begin
            in_valid = (acc_cnt < 192);
            in_data  = 16'(acc_cnt);
            cycle();
            n++;
        end
        check("bp_outputs", out_cnt, 192);

        // Random stalls over ten blocks
        do_reset();
        n = 0;
        while (out_cnt < 640 && n < 20000) begin
            in_valid  = (acc_cnt < 640) && ($urandom_range(0, 1) == 1);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            cycle();
            n++;
        end
        check("rnd_outputs", out_cnt, 640);

        // Asynchronous reset mid-operation
        do_reset();
        out_ready = 1'b1;
        n = 0;
        while ((acc_cnt < 94 || out_cnt < 10) && n < 300) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            cycle();
            n++;
        end
        check("mid_outputs_seen", out_cnt >= 10, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_ready", in_ready, 1);
        in_valid = 1'b0;
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        send_block(1'b1);
        drain("arst_fresh", 200);

        // Flush coinciding with the 64th transfer
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 63; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i + 100);
            cycle();
        end
        in_data = 16'd163;
        clr     = 1'b1;
        cycle();
        clr      = 1'b0;
        in_valid = 1'b0;
        for (int t = 0; t < 70; t++) begin
            check("clr_no_valid", out_valid, 0);
            check("clr_ready", in_ready, 1);
            cycle();
        end
        send_block(1'b1);
        drain("clr_fresh", 200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
